// File: rtl/weighted_rr_packet_arbiter.sv
// weighted_rr_packet_arbiter
//   N-way round-robin arbiter with packet lock and a per-requester packet quota.
//   The owner keeps the registered one-hot grant until its packet ends ('last'
//   accepted). It may continue bubble-free for up to WEIGHT packets. After that
//   the grant is released, followed by one idle cycle and a fresh round-robin
//   arbitration among unmasked requesters.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   req[N]     per-requester request, held through the last beat of a packet
//   last[N]    per-requester end-of-packet flag, qualified by the transfer
//   mask[N]    1 = excluded from new arbitration (current owner unaffected)
//   weight     N packed quota fields of WEIGHT_W bits; 0 behaves as 1
//   ready      downstream accepts the current beat
//   grant[N]   registered one-hot grant
//   grant_idx  binary index of the owner, meaningful while grant_vld
//   grant_vld  grant is non-zero
module weighted_rr_packet_arbiter #(
  parameter int N        = 4,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          last,
  input  logic [N-1:0]          mask,
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic                  ready,
  output logic [N-1:0]          grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  grant_vld
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    BOUNDARY
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t                state;
  logic [IDX_W-1:0]      ptr;
  logic [WEIGHT_W-1:0]   credit;

  logic [N-1:0]          elig;
  logic                  found;
  logic [IDX_W-1:0]      win;
  logic [IDX_W-1:0]      cand;
  logic [N-1:0]          win_onehot;
  logic [WEIGHT_W-1:0]   wq;
  logic [WEIGHT_W-1:0]   w_arr [N];
  logic                  xfer;
  logic                  pend;

  for (genvar i = 0; i < N; i++) begin : g_wsplit
    assign w_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
  end

  assign elig = req & ~mask;
  assign xfer = grant_vld & ready & req[grant_idx];
  assign pend = xfer & last[grant_idx];

  // Circular scan starting just after the last owner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win == IDX_W'(i)) win_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    wq = w_arr[win];
    if (wq == '0) wq = WEIGHT_W'(1);
  end

  // BUSY and BOUNDARY share the end-of-packet path: a single-beat packet
  // transferred in BOUNDARY is consumed from the quota like any other.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      grant_vld <= 1'b0;
      ptr       <= LAST_IDX;
      credit    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant     <= win_onehot;
            grant_idx <= win;
            grant_vld <= 1'b1;
            credit    <= wq;
            state     <= BUSY;
          end
        end
        BUSY, BOUNDARY: begin
          if (state == BOUNDARY && !req[grant_idx]) begin
            grant     <= '0;
            grant_vld <= 1'b0;
            ptr       <= grant_idx;
            credit    <= '0;
            state     <= IDLE;
          end else if (pend) begin
            if (credit == WEIGHT_W'(1)) begin
              grant     <= '0;
              grant_vld <= 1'b0;
              ptr       <= grant_idx;
              credit    <= '0;
              state     <= IDLE;
            end else begin
              credit <= credit - WEIGHT_W'(1);
              state  <= BOUNDARY;
            end
          end else if (state == BOUNDARY) begin
            state <= BUSY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weighted_rr_packet_arbiter.sv
module tb_weighted_rr_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  last = '0;
  logic [3:0]  mask = '0;
  logic [15:0] weight = 16'h1111;
  logic        ready = 1'b0;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        grant_vld;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] g;
    logic       in_rst;
    string      tag;
    int         cyc;
  } exp_t;

  exp_t  exp_q[$];
  string tname = "reset";
  int    cyc = 0;

  weighted_rr_packet_arbiter #(
    .N(4),
    .WEIGHT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .last(last),
    .mask(mask),
    .weight(weight),
    .ready(ready),
    .grant(grant),
    .grant_idx(grant_idx),
    .grant_vld(grant_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] oh2idx(input logic [3:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Drive one cycle of inputs and record the grant expected after the next edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lst,
                      input logic [3:0] msk, input logic rdy, input logic [3:0] eg);
    exp_t e;
    @(negedge clk);
    rst   = r;
    req   = rq;
    last  = lst;
    mask  = msk;
    ready = rdy;
    cyc++;
    e.g = eg;
    e.in_rst = r;
    e.tag = tname;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic start_test(input string name, input logic [15:0] w);
    @(negedge clk);
    tname  = name;
    cyc    = 0;
    weight = w;
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    cyc = 0;
  endtask

  // Monitor: protocol tracking at the edge, scoreboard compare just after it.
  logic [3:0] in_pkt = '0;
  initial begin
    exp_t e;
    logic [1:0] ei;
    forever begin
      @(posedge clk);
      if (rst) begin
        in_pkt = '0;
      end else if (grant_vld) begin
        if (in_pkt[grant_idx] && !req[grant_idx]) begin
          $display("FAIL protocol: req[%0d] dropped mid-packet (req=%b), required held high",
                   grant_idx, req);
          miscompares++;
        end
        if (ready && req[grant_idx]) in_pkt[grant_idx] = !last[grant_idx];
      end
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ei = oh2idx(e.g);
        vectors++;
        if (grant !== e.g || grant_vld !== (|e.g) ||
            ((|e.g || e.in_rst) && grant_idx !== ei)) begin
          $display("FAIL %s cyc%0d: grant=%b vld=%b idx=%0d, required grant=%b vld=%b idx=%0d",
                   e.tag, e.cyc, grant, grant_vld, grant_idx, e.g, |e.g, ei);
          miscompares++;
        end
      end
    end
  end

  initial begin
    int wait_cycles;

    // Basic rotation: 0,1,2,3,0 each followed by one idle cycle.
    start_test("rotation", 16'h1111);
    for (int i = 0; i < 10; i++)
      step(1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b1,
           (i % 2 == 1) ? 4'b0000 : 4'(1 << ((i / 2) % 4)));
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000);

    // Weighted quota: owner 1 holds for three back-to-back packets.
    start_test("weighted", 16'h1131);
    step(1'b0, 4'b0011, 4'b1111, 4'b0000, 1'b1, 4'b0001);
    step(1'b0, 4'b0011, 4'b1111, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b0011, 4'b1111, 4'b0000, 1'b1, 4'b0010);
    step(1'b0, 4'b0011, 4'b1111, 4'b0000, 1'b1, 4'b0010);
    step(1'b0, 4'b0011, 4'b1111, 4'b0000, 1'b1, 4'b0010);
    step(1'b0, 4'b0011, 4'b1111, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b0011, 4'b1111, 4'b0000, 1'b1, 4'b0001);
    step(1'b0, 4'b0011, 4'b1111, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000);

    // Packet lock: 5-beat packet from 2 with ready toggling; req[3] waits.
    start_test("lock", 16'h1111);
    step(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0100);
    step(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0100);
    for (int i = 0; i < 6; i++)
      step(1'b0, 4'b1100, 4'b0000, 4'b0000, (i % 2 == 1), 4'b0100);
    step(1'b0, 4'b1100, 4'b0100, 4'b0000, 1'b0, 4'b0100);
    step(1'b0, 4'b1100, 4'b0100, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b1000);
    step(1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000);

    // Early release: owner 0 with quota 4 stops after one packet.
    start_test("early_release", 16'h1114);
    step(1'b0, 4'b0011, 4'b0011, 4'b0000, 1'b1, 4'b0001);
    step(1'b0, 4'b0011, 4'b0011, 4'b0000, 1'b1, 4'b0001);
    step(1'b0, 4'b0010, 4'b0011, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0010);
    step(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000);

    // Mask: masked 1 loses to 2; masking the owner has no effect until release.
    start_test("mask", 16'h1111);
    step(1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0001);
    step(1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b0110, 4'b0000, 4'b0010, 1'b1, 4'b0100);
    step(1'b0, 4'b0110, 4'b0000, 4'b0110, 1'b1, 4'b0100);
    step(1'b0, 4'b0110, 4'b0100, 4'b0110, 1'b1, 4'b0000);
    step(1'b0, 4'b0110, 4'b0000, 4'b0110, 1'b1, 4'b0000);
    step(1'b0, 4'b0110, 4'b0000, 4'b0000, 1'b1, 4'b0010);
    step(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000);

    // Reset mid-packet, then arbitration restarts with requester 0 first.
    start_test("reset_mid", 16'h1111);
    step(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001);
    step(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001);
    step(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001);
    step(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b1, 4'b0001);
    step(1'b0, 4'b1001, 4'b0001, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b1000);
    step(1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000);

    // Zero weight field grants exactly one packet.
    start_test("weight_zero", 16'h0000);
    step(1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0100);
    step(1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
